regfile_write_arbiter: RTL

- Sequences the single write port of the 16-word, 32-bit general-purpose register file.
- Round-robin arbitrates two writeback requesters (port 0: ALU/execute, port 1: memory load) with a valid/ready handshake.
- Drives the register file's data_in/addr_in from a registered stage.
- Keeps a per-register pending-write scoreboard so decode can stall on RAW hazards.
- r0 is the zero register: never written, never busy; address 0 on the write port means "no write".

---
 rtl/regfile_write_arbiter.sv | 91 +++++++++
 1 files changed

// File: rtl/regfile_write_arbiter.sv
// Write-port sequencer for the 16x32 register file: round-robin arbitration of two
// writeback ports, a registered write stage, and a per-register pending-write scoreboard.
module regfile_write_arbiter #(
  parameter int WORDS        = 16,
  parameter int BITS         = 32,
  parameter int ADDRESS_BITS = $clog2(WORDS)
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic                    req0_valid,
  input  logic [ADDRESS_BITS-1:0] req0_addr,
  input  logic [BITS-1:0]         req0_data,
  output logic                    req0_ready,
  input  logic                    req1_valid,
  input  logic [ADDRESS_BITS-1:0] req1_addr,
  input  logic [BITS-1:0]         req1_data,
  output logic                    req1_ready,
  input  logic                    rsv_valid,
  input  logic [ADDRESS_BITS-1:0] rsv_addr,
  input  logic [ADDRESS_BITS-1:0] chk_addr_a,
  input  logic [ADDRESS_BITS-1:0] chk_addr_b,
  output logic                    busy_a,
  output logic                    busy_b,
  output logic [BITS-1:0]         rf_data_in,
  output logic [ADDRESS_BITS-1:0] rf_addr_in,
  output logic                    grant_id
);

  // tie_q=1 means port 1 wins the next tie (port 0 was granted most recently)
  logic                    tie_q, tie_d;
  logic [WORDS-1:0]        busy_q, busy_d;
  logic [ADDRESS_BITS-1:0] addr_q, addr_d;
  logic [BITS-1:0]         data_q, data_d;
  logic                    grant_q, grant_d;

  assign req0_ready = req0_valid && (!req1_valid || !tie_q);
  assign req1_ready = req1_valid && (!req0_valid || tie_q);

  assign busy_a     = busy_q[chk_addr_a];
  assign busy_b     = busy_q[chk_addr_b];
  assign rf_addr_in = addr_q;
  assign rf_data_in = data_q;
  assign grant_id   = grant_q;

  always_comb begin
    tie_d   = tie_q;
    addr_d  = '0;
    data_d  = data_q;
    grant_d = grant_q;
    if (req0_ready) begin
      addr_d  = req0_addr;
      data_d  = req0_data;
      grant_d = 1'b0;
      tie_d   = 1'b1;
    end else if (req1_ready) begin
      addr_d  = req1_addr;
      data_d  = req1_data;
      grant_d = 1'b1;
      tie_d   = 1'b0;
    end
  end

  // Commit clears before reserve sets, so a same-edge reservation stays pending
  always_comb begin
    busy_d = busy_q;
    for (int i = 1; i < WORDS; i++) begin
      if (addr_q == ADDRESS_BITS'(i))
        busy_d[i] = 1'b0;
      if (rsv_valid && rsv_addr == ADDRESS_BITS'(i))
        busy_d[i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      tie_q   <= 1'b0;
      busy_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      grant_q <= 1'b0;
    end else begin
      tie_q   <= tie_d;
      busy_q  <= busy_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      grant_q <= grant_d;
    end
  end

endmodule
